pipeline_hazard_ctrl: RTL
=========================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255 (8-bit), the maximum number of consecutive data-memory wait cycles before a fault.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: the reset; asynchronous, active-low.
REQ-004 SHALL have port idex_MemRead, input, 1 bit: the instruction in EX is a load.
REQ-005 SHALL have port idex_rd, input, 5 bits: destination register of the instruction in EX.
REQ-006 SHALL have ports ifid_rs1 and ifid_rs2, input, 5 bits each: source registers of the instruction in ID.
REQ-007 SHALL have port ex_branch_taken, input, 1 bit: a branch resolved taken in EX this cycle.
REQ-008 SHALL have ports dmem_req and dmem_ready, input, 1 bit each: MEM-stage access pending, and that access completing this cycle.
REQ-009 SHALL have ports pc_write and ifid_write, output, 1 bit each: PC and IF/ID register update enables.
REQ-010 SHALL have port ifid_flush, output, 1 bit: clear IF/ID to a NOP.
REQ-011 SHALL have port ControlMux, output, 1 bit: zero the ID/EX control fields (bubble).
REQ-012 SHALL have port pipe_hold, output, 1 bit: hold ID/EX, EX/MEM and MEM/WB unchanged.
REQ-013 SHALL have port mem_timeout, output, 1 bit: sticky memory-wait fault flag.
REQ-014 SHALL have ports stall_cycles and flush_count, output, 32 bits each: performance counters.

Function
REQ-015 SHALL implement FSM states RUN, MEM_WAIT and FAULT, using an 8-bit wait counter wait_cnt.
REQ-016 SHALL define freeze = dmem_req AND NOT dmem_ready.
REQ-017 SHALL define load_use = idex_MemRead AND idex_rd != 0 AND (idex_rd == ifid_rs1 OR idex_rd == ifid_rs2).
REQ-018 SHALL generate outputs combinationally each cycle, applying the first matching rule in priority order (REQ-019 to REQ-023).
REQ-019 In state FAULT: pc_write = 0, ifid_write = 0, pipe_hold = 1, ControlMux = 0, ifid_flush = 0.
REQ-020 When freeze: pc_write = 0, ifid_write = 0, pipe_hold = 1, ControlMux = 0, ifid_flush = 0; a simultaneous branch or load-use is deferred, not dropped, because the inputs persist while the pipeline is frozen.
REQ-021 When ex_branch_taken: pc_write = 1, ifid_write = 1, ifid_flush = 1, ControlMux = 1, pipe_hold = 0; this overrides load_use in the same cycle.
REQ-022 When load_use: pc_write = 0, ifid_write = 0, ControlMux = 1, ifid_flush = 0, pipe_hold = 0; exactly one bubble is inserted per load-use pair.
REQ-023 Otherwise: pc_write = 1, ifid_write = 1, all other control outputs 0.
REQ-024 RUN -> MEM_WAIT when freeze, with wait_cnt set to 1.
REQ-025 MEM_WAIT -> RUN when not freeze, with wait_cnt cleared.
REQ-026 In MEM_WAIT with freeze: wait_cnt increments; when wait_cnt == TIMEOUT, the next state is FAULT.
REQ-027 FAULT SHALL be left only by reset; mem_timeout = 1 exactly while in FAULT.
REQ-028 SHALL treat a dmem_ready that arrives in the same cycle as dmem_req as a zero-wait access: no freeze and no state change.

Reset
REQ-029 On rst_n low, asynchronously: state = RUN, wait_cnt = 0, mem_timeout = 0, stall_cycles = 0, flush_count = 0.
REQ-030 Reset SHALL abort an in-progress MEM_WAIT or FAULT with no residual hold; outputs follow REQ-023 while in reset, given idle inputs.

Configuration
REQ-031 With macro HAZ_PERF_CNT_EN defined: stall_cycles increments on every cycle with pc_write = 0, and flush_count increments on every cycle with ifid_flush = 1; both saturate at 0xFFFFFFFF.
REQ-032 Without HAZ_PERF_CNT_EN: both ports are present and tied to 0, and no counter flops are built.

Verification
REQ-033 Load-use check: idex_MemRead=1, idex_rd=5, ifid_rs2=5 for one cycle -> ControlMux=1, pc_write=0, ifid_write=0 for exactly 1 cycle; idex_rd=0 with ifid_rs1=0 -> no stall.
REQ-034 Branch over load-use: ex_branch_taken=1 together with load_use -> ifid_flush=1, ControlMux=1, pc_write=1; flush_count +1.
REQ-035 Memory wait: dmem_req=1, dmem_ready=0 for 3 cycles, then ready=1 -> pipe_hold=1 and pc_write=0 for 3 cycles, state returns to RUN, stall_cycles +3.
REQ-036 Timeout: TIMEOUT=4, dmem_ready held 0 -> mem_timeout=1 after the 5th wait cycle and stays 1 after dmem_ready=1; rst_n pulse clears it.
REQ-037 Reset mid-wait: rst_n low asynchronously during MEM_WAIT -> outputs immediately follow REQ-023 with counters 0, no clock edge needed.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Hazard and stall controller for a classic 5-stage in-order pipeline.
// Resolves data-memory freezes, taken-branch flushes and load-use bubbles
// with a fixed priority, and watches memory waits for a timeout fault.
// Optional build macro: HAZ_PERF_CNT_EN enables the saturating performance
// counters stall_cycles and flush_count (otherwise both read as 0).

module pipeline_hazard_ctrl #(
   parameter logic [7:0] TIMEOUT = 8'd255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        idex_MemRead,
   input  logic [4:0]  idex_rd,
   input  logic [4:0]  ifid_rs1,
   input  logic [4:0]  ifid_rs2,
   input  logic        ex_branch_taken,
   input  logic        dmem_req,
   input  logic        dmem_ready,
   output logic        pc_write,
   output logic        ifid_write,
   output logic        ifid_flush,
   output logic        ControlMux,
   output logic        pipe_hold,
   output logic        mem_timeout,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_count
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      FAULT    = 2'd2
   } state_t;

   state_t     state;
   state_t     state_next;
   logic [7:0] wait_cnt;
   logic [7:0] wait_cnt_next;

   logic freeze;
   logic load_use;

   // A ready in the same cycle as the request is a zero-wait access.
   assign freeze = dmem_req & ~dmem_ready;

   // x0 is hard-wired zero, so a load "writing" it never creates a hazard.
   assign load_use = idex_MemRead && (idex_rd != 5'd0) &&
                     ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));

   // The fault flag is a direct decode of the sticky FAULT state.
   assign mem_timeout = (state == FAULT);

   // State register and wait counter; reset aborts any wait or fault.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= RUN;
         wait_cnt <= 8'd0;
      end else begin
         state    <= state_next;
         wait_cnt <= wait_cnt_next;
      end
   end

   // Next-state logic: count consecutive frozen cycles, fault on timeout.
   always_comb begin
      state_next    = state;
      wait_cnt_next = wait_cnt;
      case (state)
         RUN: begin
            if (freeze) begin
               state_next    = MEM_WAIT;
               wait_cnt_next = 8'd1;
            end
         end
         MEM_WAIT: begin
            if (!freeze) begin
               state_next    = RUN;
               wait_cnt_next = 8'd0;
            end else if (wait_cnt == TIMEOUT) begin
               // Counter holds here so it cannot wrap when TIMEOUT is 255.
               state_next = FAULT;
            end else begin
               wait_cnt_next = wait_cnt + 8'd1;
            end
         end
         FAULT: begin
            state_next = FAULT;
         end
         default: begin
            state_next    = RUN;
            wait_cnt_next = 8'd0;
         end
      endcase
   end

   // Output decode: fault, then freeze, then branch, then load-use.
   // While frozen the branch/load-use inputs persist, so they are simply
   // acted on once the freeze lifts.
   always_comb begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      ifid_flush = 1'b0;
      ControlMux = 1'b0;
      pipe_hold  = 1'b0;
      if (state == FAULT || freeze) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         pipe_hold  = 1'b1;
      end else if (ex_branch_taken) begin
         ifid_flush = 1'b1;
         ControlMux = 1'b1;
      end else if (load_use) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         ControlMux = 1'b1;
      end
   end

`ifdef HAZ_PERF_CNT_EN
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;

   // Saturating counters of PC-stalled cycles and IF/ID flush cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= 32'd0;
         flush_cnt <= 32'd0;
      end else begin
         if (!pc_write && (stall_cnt != 32'hFFFF_FFFF))
            stall_cnt <= stall_cnt + 32'd1;
         if (ifid_flush && (flush_cnt != 32'hFFFF_FFFF))
            flush_cnt <= flush_cnt + 32'd1;
      end
   end

   assign stall_cycles = stall_cnt;
   assign flush_count  = flush_cnt;
`else
   assign stall_cycles = 32'd0;
   assign flush_count  = 32'd0;
`endif

endmodule
